button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 31 +++
 rtl/btn_channel.sv | 129 ++++++++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//   - btn_state_t : per-channel debounce FSM states
//   - BTN_*       : bit index of each physical button on the push bus
//   - DEF_*       : default parameter values for the conditioner
//   - max_u       : helper used to size the hold timer
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } btn_state_t;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_MIDDLE = 4;

    localparam int unsigned DEF_N_BTN           = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
    localparam int unsigned DEF_REPEAT_RATE     = 10000000;
    localparam int unsigned DEF_REPEAT_EN       = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and
// auto-repeat hold timer.
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   push          : raw asynchronous button level
//   pressed       : debounced level (registered)
//   pressed_d     : next value of pressed, lets the parent register an OR
//                   of all channels without adding a cycle of latency
//   press_pulse   : one-cycle strobe on an accepted press
//   release_pulse : one-cycle strobe on an accepted release
//   repeat_pulse  : one-cycle auto-repeat strobe while held
module btn_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    output logic pressed,
    output logic pressed_d,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned TMR_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE)) + 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    logic             sync_meta;
    logic             sync;
    btn_state_t       state;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] hold_tmr;
    logic             first_done;   // first repeat already issued in this hold

    logic             press_fire;
    logic             release_fire;
    logic [TMR_W-1:0] rep_last;

    always_comb begin
        press_fire   = (state == PRESS_CHK)   &&  sync && (db_cnt == DB_LAST);
        release_fire = (state == RELEASE_CHK) && !sync && (db_cnt == DB_LAST);
        pressed_d    = press_fire | (pressed & ~release_fire);
        rep_last     = first_done ? RATE_LAST : DELAY_LAST;
    end

    // Pulses are exclusive by construction: each one is only produced from
    // a different state, so at most one can be set on any edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta     <= 1'b0;
            sync          <= 1'b0;
            state         <= IDLE;
            db_cnt        <= '0;
            hold_tmr      <= '0;
            first_done    <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_meta     <= push;
            sync          <= sync_meta;
            pressed       <= pressed_d;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    if (sync) begin
                        state  <= PRESS_CHK;
                        db_cnt <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (press_fire) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        hold_tmr    <= '0;
                        first_done  <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state  <= RELEASE_CHK;
                        db_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // Timer restarts at each repeat, so it never
                        // saturates or wraps while the button is held.
                        if (hold_tmr == rep_last) begin
                            repeat_pulse <= 1'b1;
                            hold_tmr     <= '0;
                            first_done   <= 1'b1;
                        end else begin
                            hold_tmr <= hold_tmr + 1'b1;
                        end
                    end
                end
                RELEASE_CHK: begin
                    // Hold timer is frozen here so a bounce back to HELD
                    // resumes the repeat schedule where it left off.
                    if (sync) begin
                        state <= HELD;
                    end else if (release_fire) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounce, edge-detect and auto-repeat for a bank of push buttons.
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   push          : raw button levels (0=up,1=down,2=left,3=right,4=middle)
//   pressed       : debounced levels
//   press_pulse   : one-cycle strobe per accepted press
//   release_pulse : one-cycle strobe per accepted release
//   repeat_pulse  : one-cycle auto-repeat strobe while held
//   any_pressed   : OR of pressed, registered alongside it
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] push,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_pressed
);

    logic [N_BTN-1:0] pressed_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (REPEAT_EN)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .push          (push[g]),
            .pressed       (pressed[g]),
            .pressed_d     (pressed_d[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .repeat_pulse  (repeat_pulse[g])
        );
    end

    // Registered from the channels' next-state so it tracks pressed exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |pressed_d;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] push;

    logic [4:0] pressed, press_pulse, release_pulse, repeat_pulse;
    logic       any_pressed;
    logic [4:0] nr_pressed, nr_press_pulse, nr_release_pulse, nr_repeat_pulse;
    logic       nr_any_pressed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_EN       (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_pressed   (any_pressed)
    );

    button_conditioner #(
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_EN       (0)
    ) dut_nr (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pressed       (nr_pressed),
        .press_pulse   (nr_press_pulse),
        .release_pulse (nr_release_pulse),
        .repeat_pulse  (nr_repeat_pulse),
        .any_pressed   (nr_any_pressed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: active edge, then land on the falling edge to sample/drive.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pressed"}, pressed,       '0);
        check({tag, "_press"},   press_pulse,   '0);
        check({tag, "_release"}, release_pulse, '0);
        check({tag, "_repeat"},  repeat_pulse,  '0);
        check({tag, "_any"},     any_pressed,   '0);
    endtask

    // After step k (k=1 is the first edge sampling a new push level),
    // outputs reflect edge E+k-1: 2 sync flops, IDLE->PRESS_CHK, then
    // 4 debounce counts, so the strobe is seen at k=7.
    initial begin
        reset = 1'b1;
        push  = '0;
        @(negedge clk);
        check_all_zero("reset");
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check_all_zero("idle");

        // Clean press and release on up.
        push = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("A_press",   press_pulse,  (k == 7) ? 5'b00001 : 5'b00000);
            check("A_pressed", pressed,      (k >= 7) ? 5'b00001 : 5'b00000);
            check("A_repeat",  repeat_pulse, 5'b00000);
        end
        push = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("A_release", release_pulse, (k == 7) ? 5'b00001 : 5'b00000);
            check("A_pressed_rel", pressed,   (k >= 7) ? 5'b00000 : 5'b00001);
            check("A_press_rel", press_pulse, 5'b00000);
        end

        // Bouncing left: 3 high / 1 low, five times, never accepted.
        for (int i = 0; i < 28; i++) begin
            push = ((i < 20) && ((i % 4) != 3)) ? 5'b00100 : 5'b00000;
            step();
            check("B_pressed", pressed,       '0);
            check("B_press",   press_pulse,   '0);
            check("B_release", release_pulse, '0);
        end

        // Middle held: repeats at +10, +13, ..., +28 after press_pulse.
        push = 5'b10000;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("C_press",    press_pulse,    (k == 7) ? 5'b10000 : 5'b00000);
            check("C_nr_press", nr_press_pulse, (k == 7) ? 5'b10000 : 5'b00000);
        end
        for (int j = 1; j <= 30; j++) begin
            step();
            check("C_repeat",    repeat_pulse,
                  ((j >= 10) && (((j - 10) % 3) == 0)) ? 5'b10000 : 5'b00000);
            check("C_nr_repeat", nr_repeat_pulse, '0);
            check("C_press_hold", press_pulse,    '0);
            check("C_pressed",   pressed,         5'b10000);
        end
        push = 5'b00000;
        for (int k = 1; k <= 9; k++) step();
        check("C_pressed_end",    pressed,    '0);
        check("C_nr_pressed_end", nr_pressed, '0);

        // Down: release with a 2-sample high glitch inside the release check.
        push = 5'b00010;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("D_press", press_pulse, (k == 7) ? 5'b00010 : 5'b00000);
        end
        for (int k = 1; k <= 14; k++) begin
            push = ((k == 3) || (k == 4)) ? 5'b00010 : 5'b00000;
            step();
            check("D_release", release_pulse, (k == 11) ? 5'b00010 : 5'b00000);
            check("D_press_g", press_pulse,   '0);
            check("D_pressed", pressed,       (k < 11) ? 5'b00010 : 5'b00000);
        end

        // Up and right together.
        push = 5'b01001;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("E_press", press_pulse, (k == 7) ? 5'b01001 : 5'b00000);
            check("E_any",   any_pressed, (k >= 7) ? 1'b1 : 1'b0);
        end

        // Reset mid-hold: immediate clear, then a fresh press, no release.
        reset = 1'b1;
        #1;
        check("F_async_pressed", pressed,     '0);
        check("F_async_any",     any_pressed, '0);
        step();
        check_all_zero("F_rst1");
        step();
        check_all_zero("F_rst2");
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("F_press",   press_pulse,   (k == 7) ? 5'b01001 : 5'b00000);
            check("F_release", release_pulse, '0);
            check("F_pressed", pressed,       (k >= 7) ? 5'b01001 : 5'b00000);
        end

        push = 5'b00000;
        for (int k = 1; k <= 9; k++) step();
        check("end_pressed", pressed,     '0);
        check("end_any",     any_pressed, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
